// File: rtl/alarm_zone_ctrl.sv
// N-zone intruder alarm controller: exit/entry delays, instant/delayed zones, timed siren.
// Optional zone bypass is compiled in with `define ALARM_ZONE_BYPASS_EN.
module alarm_zone_ctrl #(
  parameter int NZONES       = 4,
  parameter     INSTANT_MASK = 4'b0001,
  parameter int EXIT_DELAY   = 4,
  parameter int ENTRY_DELAY  = 3,
  parameter int SIREN_TIME   = 6,
  localparam int MAXD = (EXIT_DELAY > ENTRY_DELAY)
                        ? ((EXIT_DELAY > SIREN_TIME) ? EXIT_DELAY : SIREN_TIME)
                        : ((ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME),
  localparam int CW = $clog2(MAXD + 1)
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              arm,
  input  logic [NZONES-1:0] sensor,
  input  logic [NZONES-1:0] bypass,
  output logic              siren,
  output logic              armed,
  output logic [NZONES-1:0] tripped,
  output logic [CW-1:0]     count,
  output logic [2:0]        state
);

  if (NZONES < 1 || NZONES > 8) begin : g_bad_nzones
    $error("alarm_zone_ctrl: NZONES must be in 1..8");
  end
  if (EXIT_DELAY < 1 || ENTRY_DELAY < 1 || SIREN_TIME < 1) begin : g_bad_delay
    $error("alarm_zone_ctrl: delays must be >= 1");
  end
  if ($bits(INSTANT_MASK) != NZONES) begin : g_bad_mask
    $error("alarm_zone_ctrl: INSTANT_MASK width must equal NZONES");
  end

  localparam logic [NZONES-1:0] IMASK     = INSTANT_MASK;
  localparam logic [CW-1:0]     C_ONE     = CW'(1);
  localparam logic [CW-1:0]     C_EXIT    = CW'(EXIT_DELAY);
  localparam logic [CW-1:0]     C_ENTRY   = CW'(ENTRY_DELAY);
  localparam logic [CW-1:0]     C_SIREN   = CW'(SIREN_TIME);

  typedef enum logic [2:0] {
    S_DISARMED   = 3'd0,
    S_EXIT_WAIT  = 3'd1,
    S_ARMED      = 3'd2,
    S_ENTRY_WAIT = 3'd3,
    S_ALARM      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              siren_q, siren_d;
  logic              armed_q, armed_d;
  logic [NZONES-1:0] tripped_q, tripped_d;
  logic [NZONES-1:0] bypass_eff, eff;
  logic              inst, dly;

`ifdef ALARM_ZONE_BYPASS_EN
  // Bypass is frozen at arming so it cannot be changed while the system is armed.
  logic [NZONES-1:0] bypass_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      bypass_q <= '0;
    end else if (state_q == S_DISARMED && state_d == S_EXIT_WAIT) begin
      bypass_q <= bypass;
    end
  end

  assign bypass_eff = (state_q == S_DISARMED) ? bypass : bypass_q;
`else
  logic unused_bypass;
  assign unused_bypass = ^bypass;
  assign bypass_eff    = '0;
`endif

  assign eff  = sensor & ~bypass_eff;
  assign inst = |(eff & IMASK);
  assign dly  = |(eff & ~IMASK);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tripped_d = tripped_q;
    if (!arm) begin
      state_d = S_DISARMED;
      count_d = '0;
    end else begin
      if (state_q == S_ARMED || state_q == S_ENTRY_WAIT || state_q == S_ALARM) begin
        tripped_d = tripped_q | eff;
      end
      unique case (state_q)
        S_DISARMED: begin
          state_d   = S_EXIT_WAIT;
          count_d   = C_EXIT;
          tripped_d = '0;
        end
        S_EXIT_WAIT: begin
          if (count_q == C_ONE) begin
            state_d = S_ARMED;
            count_d = '0;
          end else begin
            count_d = count_q - C_ONE;
          end
        end
        S_ARMED: begin
          if (inst) begin
            state_d = S_ALARM;
            count_d = C_SIREN;
          end else if (dly) begin
            state_d = S_ENTRY_WAIT;
            count_d = C_ENTRY;
          end
        end
        S_ENTRY_WAIT: begin
          if (inst || count_q == C_ONE) begin
            state_d = S_ALARM;
            count_d = C_SIREN;
          end else begin
            count_d = count_q - C_ONE;
          end
        end
        S_ALARM: begin
          // Further trips are only recorded; the siren timer is never restarted.
          if (count_q == C_ONE) begin
            state_d = S_ARMED;
            count_d = '0;
          end else begin
            count_d = count_q - C_ONE;
          end
        end
        default: begin
          state_d = S_DISARMED;
          count_d = '0;
        end
      endcase
    end
    siren_d = (state_d == S_ALARM);
    armed_d = (state_d == S_ARMED) || (state_d == S_ENTRY_WAIT) || (state_d == S_ALARM);
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_DISARMED;
      count_q   <= '0;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
      tripped_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      siren_q   <= siren_d;
      armed_q   <= armed_d;
      tripped_q <= tripped_d;
    end
  end

  assign state   = state_q;
  assign count   = count_q;
  assign siren   = siren_q;
  assign armed   = armed_q;
  assign tripped = tripped_q;

endmodule
